// File: rtl/jpeg_rle_coef_decoder_pkg.sv
// Shared types, constants and the amplitude sign-extension helper for the
// JPEG run-length coefficient decoder.
package jpeg_dec_pkg;

  localparam int COEF_W = 12;
  localparam int NCOMP  = 3;

  localparam logic [5:0] LAST_IDX = 6'd63;
  // EOB is run=0,size=0; ZRL is run=15,size=0 (sixteen zeros). With size=0
  // the extended value is zero, so a ZRL is simply "15 zeros then a zero".
  localparam logic [3:0] EOB_RUN  = 4'd0;
  localparam logic [3:0] ZRL_RUN  = 4'd15;

  typedef enum logic [1:0] {
    S_DC   = 2'd0,
    S_AC   = 2'd1,
    S_ZERO = 2'd2,
    S_PAD  = 2'd3
  } state_t;

  // JPEG EXTEND: a cleared top amplitude bit marks a negative value that is
  // stored as its ones' complement, so subtract (2^size - 1).
  function automatic logic [COEF_W-1:0] jpeg_extend(input logic [COEF_W-1:0] amp,
                                                    input logic [3:0]        size);
    logic [15:0] mask;
    logic [15:0] a;
    logic [15:0] r;
    mask = (16'd1 << size) - 16'd1;
    a    = 16'(amp) & mask;
    if (size == 4'd0)
      r = 16'd0;
    else if (a[size - 4'd1] == 1'b0)
      r = a - mask;
    else
      r = a;
    return r[COEF_W-1:0];
  endfunction

endpackage

// File: rtl/jpeg_rle_coef_decoder_if.sv
// Symbol input and coefficient output bundle of the coefficient decoder.
interface jpeg_rle_coef_decoder_if;
  import jpeg_dec_pkg::*;

  logic              sym_valid;
  logic              sym_ready;
  logic [3:0]        sym_run;
  logic [3:0]        sym_size;
  logic [COEF_W-1:0] sym_amp;
  logic [1:0]        sym_comp;
  logic              restart;
  logic              coef_valid;
  logic              coef_ready;
  logic [COEF_W-1:0] coef_data;
  logic [5:0]        coef_idx;
  logic              coef_last;
  logic              err;

  modport slave (
    input  sym_valid, sym_run, sym_size, sym_amp, sym_comp, restart, coef_ready,
    output sym_ready, coef_valid, coef_data, coef_idx, coef_last, err
  );

  modport master (
    output sym_valid, sym_run, sym_size, sym_amp, sym_comp, restart, coef_ready,
    input  sym_ready, coef_valid, coef_data, coef_idx, coef_last, err
  );
endinterface

// File: rtl/jpeg_dc_predictor.sv
// Per-component DC predictors: combinational sum of the selected predictor
// and a difference, registered back when add_en is set; clr zeroes all.
module jpeg_dc_predictor
  import jpeg_dec_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              add_en,
  input  logic [1:0]        comp,
  input  logic [COEF_W-1:0] diff,
  output logic [COEF_W-1:0] sum
);

  logic [COEF_W-1:0] pred_q [NCOMP];
  logic [COEF_W-1:0] pred_d [NCOMP];
  logic [COEF_W-1:0] base;

  // Pick the addressed predictor; a clear in the same cycle takes effect first.
  always_comb begin
    base = '0;
    for (int i = 0; i < NCOMP; i++) begin
      if (!clr && comp == 2'(i)) base = pred_q[i];
    end
    sum = base + diff;
  end

  // Next predictor values: optional clear, then the accumulated DC for comp.
  always_comb begin
    for (int i = 0; i < NCOMP; i++) begin
      pred_d[i] = clr ? '0 : pred_q[i];
      if (add_en && comp == 2'(i)) pred_d[i] = sum;
    end
  end

  // Predictor registers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCOMP; i++) begin
      if (!rst_n) pred_q[i] <= '0;
      else        pred_q[i] <= pred_d[i];
    end
  end

endmodule

// File: rtl/jpeg_rle_coef_decoder.sv
// Expands (run,size,amplitude) symbols into 64 zigzag-ordered coefficients
// per block, restoring DC from per-component predictors.
module jpeg_rle_coef_decoder
  import jpeg_dec_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  jpeg_rle_coef_decoder_if.slave   bus
);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [COEF_W-1:0] val_q, val_d;
  logic              err_q, err_d;
  logic              active_q;
  logic              coef_valid_q, coef_valid_d;
  logic [COEF_W-1:0] coef_data_q, coef_data_d;
  logic [5:0]        coef_idx_q, coef_idx_d;
  logic              coef_last_q, coef_last_d;

  logic              slot_free, sym_ready, sym_fire, is_eob;
  logic [COEF_W-1:0] ext_val, pred_sum, emit_data;
  logic [5:0]        next_idx, emit_idx;
  logic              emit, pred_clr, pred_add;

  jpeg_dc_predictor u_pred (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (pred_clr),
    .add_en (pred_add),
    .comp   (bus.sym_comp),
    .diff   (ext_val),
    .sum    (pred_sum)
  );

  // Block expansion: decide what (if anything) goes into the output slot.
  always_comb begin
    slot_free = !coef_valid_q || bus.coef_ready;
    sym_ready = active_q && slot_free && (state_q == S_DC || state_q == S_AC);
    sym_fire  = bus.sym_valid && sym_ready;
    ext_val   = jpeg_extend(bus.sym_amp, bus.sym_size);
    next_idx  = coef_idx_q + 6'd1;
    is_eob    = (bus.sym_size == 4'd0) && (bus.sym_run == EOB_RUN);

    state_d      = state_q;
    cnt_d        = cnt_q;
    val_d        = val_q;
    err_d        = err_q;
    coef_valid_d = coef_valid_q && !bus.coef_ready;
    coef_data_d  = coef_data_q;
    coef_idx_d   = coef_idx_q;
    coef_last_d  = coef_last_q;
    pred_clr     = 1'b0;
    pred_add     = 1'b0;
    emit         = 1'b0;
    emit_data    = '0;
    emit_idx     = next_idx;

    unique case (state_q)
      S_DC: begin
        pred_clr = active_q && bus.restart;
        if (pred_clr) err_d = 1'b0;
        if (sym_fire) begin
          pred_add  = 1'b1;
          emit      = 1'b1;
          emit_data = pred_sum;
          emit_idx  = 6'd0;
          state_d   = S_AC;
        end
      end
      S_AC: begin
        if (sym_fire) begin
          emit = 1'b1;
          if (is_eob) begin
            state_d = S_PAD;
          end else if (bus.sym_run == 4'd0) begin
            emit_data = ext_val;
          end else begin
            // First zero goes out now; the rest plus the value follow.
            cnt_d   = bus.sym_run - 4'd1;
            val_d   = ext_val;
            state_d = S_ZERO;
            if (next_idx == LAST_IDX) err_d = 1'b1;
          end
        end
      end
      S_ZERO: begin
        if (slot_free) begin
          emit = 1'b1;
          if (cnt_q == 4'd0) begin
            emit_data = val_q;
            state_d   = S_AC;
          end else begin
            cnt_d = cnt_q - 4'd1;
            // A zero landing on 63 with a value still pending: value is lost.
            if (next_idx == LAST_IDX) err_d = 1'b1;
          end
        end
      end
      S_PAD: begin
        if (slot_free) emit = 1'b1;
      end
      default: state_d = S_DC;
    endcase

    if (emit) begin
      coef_valid_d = 1'b1;
      coef_data_d  = emit_data;
      coef_idx_d   = emit_idx;
      coef_last_d  = (emit_idx == LAST_IDX);
      if (emit_idx == LAST_IDX) state_d = S_DC;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_DC;
      cnt_q        <= '0;
      val_q        <= '0;
      err_q        <= 1'b0;
      active_q     <= 1'b0;
      coef_valid_q <= 1'b0;
      coef_data_q  <= '0;
      coef_idx_q   <= '0;
      coef_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      val_q        <= val_d;
      err_q        <= err_d;
      active_q     <= 1'b1;
      coef_valid_q <= coef_valid_d;
      coef_data_q  <= coef_data_d;
      coef_idx_q   <= coef_idx_d;
      coef_last_q  <= coef_last_d;
    end
  end

  assign bus.sym_ready  = sym_ready;
  assign bus.coef_valid = coef_valid_q;
  assign bus.coef_data  = coef_data_q;
  assign bus.coef_idx   = coef_idx_q;
  assign bus.coef_last  = coef_last_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_jpeg_rle_coef_decoder.sv
// Bench for jpeg_rle_coef_decoder: table of AC extend vectors plus hand-written
// block sequences; expected coefficients go into a queue as symbols are sent
// and are popped when the DUT hands a coefficient over.
module tb_jpeg_rle_coef_decoder;
  import jpeg_dec_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  jpeg_rle_coef_decoder_if bus();

  jpeg_rle_coef_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [COEF_W-1:0] data;
    logic [5:0]        idx;
    logic              last;
  } beat_t;

  typedef struct {
    logic [3:0]        run;
    logic [3:0]        size;
    logic [COEF_W-1:0] amp;
    logic [COEF_W-1:0] val;
  } ac_vec_t;

  beat_t             exp_q[$];
  ac_vec_t           tbl[12];
  int                vec_cnt = 0;
  int                mis_cnt = 0;
  int                cur_idx = 0;
  logic [COEF_W-1:0] pred[3];
  bit                bp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vec_cnt++;
    if (act !== req) begin
      mis_cnt++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Downstream ready: always 1, or a random coin flip when backpressure is on.
  initial begin
    bus.coef_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.coef_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Scoreboard and hold-stability monitor.
  initial begin : monitor
    beat_t e;
    beat_t held;
    bit    stall;
    stall = 1'b0;
    held  = '{default: '0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          vec_cnt++;
          if (!bus.coef_valid || bus.coef_data !== held.data ||
              bus.coef_idx !== held.idx || bus.coef_last !== held.last) begin
            mis_cnt++;
            $display("FAIL hold_stable: got valid=%0b data=%0h idx=%0d want data=%0h idx=%0d",
                     bus.coef_valid, bus.coef_data, bus.coef_idx, held.data, held.idx);
          end
        end
        stall = bus.coef_valid && !bus.coef_ready;
        held  = '{bus.coef_data, bus.coef_idx, bus.coef_last};
        if (bus.coef_valid && bus.coef_ready) begin
          vec_cnt++;
          if (exp_q.size() == 0) begin
            mis_cnt++;
            $display("FAIL unexpected_coef: got data=%0h idx=%0d want none",
                     bus.coef_data, bus.coef_idx);
          end else begin
            e = exp_q.pop_front();
            if (bus.coef_data !== e.data || bus.coef_idx !== e.idx || bus.coef_last !== e.last) begin
              mis_cnt++;
              $display("FAIL coef[%0d]: got data=%0d idx=%0d last=%0b want data=%0d idx=%0d last=%0b",
                       e.idx, $signed(bus.coef_data), bus.coef_idx, bus.coef_last,
                       $signed(e.data), e.idx, e.last);
            end
          end
        end
      end
    end
  end

  task automatic send_sym(input logic [3:0] run, input logic [3:0] size,
                          input logic [COEF_W-1:0] amp, input logic [1:0] comp);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    bus.sym_run   = run;
    bus.sym_size  = size;
    bus.sym_amp   = amp;
    bus.sym_comp  = comp;
    bus.sym_valid = 1'b1;
    while (!done && n < 300) begin
      @(negedge clk);
      if (bus.sym_ready) done = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    bus.sym_valid = 1'b0;
    if (!done) begin
      vec_cnt++;
      mis_cnt++;
      $display("FAIL sym_handshake: got timeout want accept (run=%0d size=%0d)", run, size);
    end
  endtask

  task automatic m_dc(input logic [3:0] size, input logic [COEF_W-1:0] amp,
                      input logic [1:0] comp, input logic [COEF_W-1:0] diff);
    pred[comp] = pred[comp] + diff;
    exp_q.push_back('{pred[comp], 6'd0, 1'b0});
    cur_idx = 1;
    send_sym(4'd0, size, amp, comp);
  endtask

  task automatic m_ac(input logic [3:0] run, input logic [3:0] size,
                      input logic [COEF_W-1:0] amp, input logic [COEF_W-1:0] val);
    int  z;
    bit  over;
    z = 0;
    over = 1'b0;
    while (z < int'(run) && !over) begin
      exp_q.push_back('{'0, 6'(cur_idx), cur_idx == 63});
      if (cur_idx == 63) over = 1'b1;
      cur_idx++;
      z++;
    end
    if (!over) begin
      exp_q.push_back('{val, 6'(cur_idx), cur_idx == 63});
      cur_idx++;
    end
    send_sym(run, size, amp, 2'd0);
  endtask

  task automatic m_eob();
    while (cur_idx <= 63) begin
      exp_q.push_back('{'0, 6'(cur_idx), cur_idx == 63});
      cur_idx++;
    end
    send_sym(4'd0, 4'd0, '0, 2'd0);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, exp_q.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_restart();
    bus.restart = 1'b1;
    @(posedge clk);
    #1;
    bus.restart = 1'b0;
    for (int i = 0; i < 3; i++) pred[i] = '0;
  endtask

  task automatic table_block();
    m_dc(4'd3, 12'h005, 2'd0, 12'h005);
    for (int i = 0; i < 12; i++) m_ac(tbl[i].run, tbl[i].size, tbl[i].amp, tbl[i].val);
    m_eob();
  endtask

  initial begin : main
    int  n;
    bit  found;
    rst_n         = 1'b0;
    bus.sym_valid = 1'b0;
    bus.sym_run   = '0;
    bus.sym_size  = '0;
    bus.sym_amp   = '0;
    bus.sym_comp  = '0;
    bus.restart   = 1'b0;
    for (int i = 0; i < 3; i++) pred[i] = '0;

    tbl[0]  = '{4'd0, 4'd1,  12'h001, 12'h001};
    tbl[1]  = '{4'd0, 4'd1,  12'h000, 12'hFFF};
    tbl[2]  = '{4'd2, 4'd3,  12'h002, 12'hFFB};
    tbl[3]  = '{4'd0, 4'd3,  12'h005, 12'h005};
    tbl[4]  = '{4'd1, 4'd11, 12'h400, 12'h400};
    tbl[5]  = '{4'd0, 4'd11, 12'h3FF, 12'hC00};
    tbl[6]  = '{4'd0, 4'd11, 12'h7FF, 12'h7FF};
    tbl[7]  = '{4'd0, 4'd11, 12'h000, 12'h801};
    tbl[8]  = '{4'd3, 4'd4,  12'h007, 12'hFF8};
    tbl[9]  = '{4'd0, 4'd2,  12'h002, 12'h002};
    tbl[10] = '{4'd0, 4'd2,  12'h001, 12'hFFE};
    tbl[11] = '{4'd0, 4'd10, 12'h200, 12'h200};

    repeat (3) @(posedge clk);
    #1;
    check("rst_sym_ready",  32'(bus.sym_ready),  32'd0);
    check("rst_coef_valid", 32'(bus.coef_valid), 32'd0);
    check("rst_coef_data",  32'(bus.coef_data),  32'd0);
    check("rst_coef_idx",   32'(bus.coef_idx),   32'd0);
    check("rst_coef_last",  32'(bus.coef_last),  32'd0);
    check("rst_err",        32'(bus.err),        32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // DC +5 then the extend table, EOB pads to 63.
    table_block();
    drain("table_block");
    check("err_table", 32'(bus.err), 32'd0);

    // Predictor accumulates: +3 -> 8.
    m_dc(4'd2, 12'h003, 2'd0, 12'h003);
    m_eob();
    drain("pred_accum");

    // Restart clears: +3 -> 3; other components independent.
    pulse_restart();
    m_dc(4'd2, 12'h003, 2'd0, 12'h003);
    m_eob();
    m_dc(4'd1, 12'h001, 2'd1, 12'h001);
    m_eob();
    m_dc(4'd2, 12'h000, 2'd2, 12'hFFD);
    m_eob();
    m_dc(4'd0, 12'h000, 2'd2, 12'h000);
    m_eob();
    drain("restart_comp");

    // Exact fill: 3x ZRL then run 14 puts the value on idx 63, no EOB needed.
    m_dc(4'd0, 12'h000, 2'd0, 12'h000);
    for (int i = 0; i < 3; i++) m_ac(ZRL_RUN, 4'd0, 12'h000, 12'h000);
    m_ac(4'd14, 4'd1, 12'h001, 12'h001);
    drain("exact_fill");
    check("err_exact_fill", 32'(bus.err), 32'd0);

    // Overflow: 3x ZRL then run 15 -> zeros to 63, value dropped, err sticky.
    m_dc(4'd0, 12'h000, 2'd0, 12'h000);
    for (int i = 0; i < 3; i++) m_ac(ZRL_RUN, 4'd0, 12'h000, 12'h000);
    m_ac(4'd15, 4'd2, 12'h003, 12'h003);
    drain("overflow");
    check("err_overflow", 32'(bus.err), 32'd1);
    m_dc(4'd1, 12'h001, 2'd0, 12'h001);
    m_eob();
    drain("after_overflow");
    check("err_sticky", 32'(bus.err), 32'd1);
    pulse_restart();
    check("err_restart_clr", 32'(bus.err), 32'd0);

    // Same table block under random backpressure.
    bp_en = 1'b1;
    table_block();
    drain("backpressure");
    bp_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset while padding at idx 20.
    m_dc(4'd3, 12'h005, 2'd0, 12'h005);
    m_ac(4'd0, 4'd1, 12'h001, 12'h001);
    m_eob();
    n = 0;
    found = 1'b0;
    while (!found && n < 200) begin
      @(negedge clk);
      if (bus.coef_valid && bus.coef_idx == 6'd20) found = 1'b1;
      n++;
    end
    check("reach_idx20", 32'(found), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_coef_valid", 32'(bus.coef_valid), 32'd0);
    check("midrst_sym_ready",  32'(bus.sym_ready),  32'd0);
    check("midrst_coef_idx",   32'(bus.coef_idx),   32'd0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) pred[i] = '0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_dc(4'd2, 12'h002, 2'd0, 12'h002);
    m_eob();
    drain("after_midrst");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule
